// File: rtl/demux_route_seq_pkg.sv
// rtl/demux_route_seq_pkg.sv - shared types and constants for the demux route sequencer
package demux_pkg;

  localparam int NUM_CH  = 32;
  localparam int SEL_W   = 5;
  localparam int DWELL_W = 8;

  typedef struct packed {
    logic [SEL_W-1:0]   sel;
    logic               data;
    logic [DWELL_W-1:0] dwell;
  } route_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2
  } seq_state_t;

  // A zero dwell still gives one enable cycle so every accepted request is visible.
  function automatic logic [DWELL_W-1:0] dwell_eff(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/demux_route_seq_if.sv
// rtl/demux_route_seq_if.sv - routing request valid/ready handshake
interface demux_route_seq_if #(
  parameter int SEL_W   = 5,
  parameter int DWELL_W = 8
);
  logic               req_valid_i;
  logic               req_ready_o;
  logic [SEL_W-1:0]   req_sel_i;
  logic               req_data_i;
  logic [DWELL_W-1:0] req_dwell_i;

  modport master (
    output req_valid_i, req_sel_i, req_data_i, req_dwell_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i, req_sel_i, req_data_i, req_dwell_i,
    output req_ready_o
  );
endinterface

// File: rtl/demux_route_seq_fifo.sv
// rtl/demux_route_seq_fifo.sv - synchronous FIFO with clear, head visible on rdata_o
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (r_level == LW'(DEPTH));
  assign empty_o   = (r_level == '0);
  assign level_o   = r_level;
  assign rdata_o   = r_mem[r_rptr];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_do_push && !clr_i) r_mem[r_wptr] <= wdata_i;
  end
endmodule

// File: rtl/demux_route_seq.sv
// rtl/demux_route_seq.sv - queues routing requests and drives demux sel/data/en break-before-make
module demux_route_seq
  import demux_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DWELL_W    = 8,
  parameter int SEL_W      = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  demux_route_seq_if.slave                  req_if,
  input  logic                              flush_i,
  output logic [SEL_W-1:0]                  sel_o,
  output logic                              data_o,
  output logic                              en_o,
  output logic                              busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o
);
  seq_state_t         r_state;
  logic [DWELL_W-1:0] r_cnt;
  route_req_t         w_wdata;
  route_req_t         w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_last;

  assign w_wdata = '{sel: req_if.req_sel_i, data: req_if.req_data_i, dwell: req_if.req_dwell_i};

  assign req_if.req_ready_o = !w_full && !flush_i && rst_ni;
  assign w_push = req_if.req_valid_i && req_if.req_ready_o;
  assign w_last = (r_cnt == DWELL_W'(1));
  // Head leaves the queue when the sequencer is free or finishing the current route.
  assign w_pop  = !flush_i && !w_empty &&
                  ((r_state == IDLE) || ((r_state == DRIVE) && w_last));
  assign busy_o = (r_state != IDLE) || (fifo_level_o != '0);

  sync_fifo #(
    .WIDTH ($bits(route_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (flush_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_wdata),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      sel_o   <= '0;
      data_o  <= 1'b0;
      en_o    <= 1'b0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      sel_o   <= '0;
      data_o  <= 1'b0;
      en_o    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          en_o <= 1'b0;
          if (w_pop) begin
            sel_o   <= w_head.sel;
            data_o  <= w_head.data;
            r_cnt   <= dwell_eff(w_head.dwell);
            r_state <= SETUP;
          end
        end
        SETUP: begin
          en_o    <= 1'b1;
          r_state <= DRIVE;
        end
        DRIVE: begin
          if (w_last) begin
            // Drop enable before any sel/data change: break-before-make.
            en_o <= 1'b0;
            if (w_pop) begin
              sel_o   <= w_head.sel;
              data_o  <= w_head.data;
              r_cnt   <= dwell_eff(w_head.dwell);
              r_state <= SETUP;
            end else begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end
        end
        default: begin
          en_o    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_demux_route_seq.sv
// tb/tb_demux_route_seq.sv - directed self-checking bench for demux_route_seq
module tb_demux_route_seq;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [4:0]  sel_o;
  logic        data_o;
  logic        en_o;
  logic        busy_o;
  logic [2:0]  level_o;
  logic [31:0] w_demux;
  int          checks;
  int          failures;
  int          n;

  demux_route_seq_if #(.SEL_W(5), .DWELL_W(8)) u_if ();

  demux_route_seq #(.FIFO_DEPTH(4), .DWELL_W(8), .SEL_W(5)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_if       (u_if.slave),
    .flush_i      (flush),
    .sel_o        (sel_o),
    .data_o       (data_o),
    .en_o         (en_o),
    .busy_o       (busy_o),
    .fifo_level_o (level_o)
  );

  // Behavioural 1-to-32 demux fed by the sequencer outputs.
  assign w_demux = en_o ? (32'(data_o) << sel_o) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic [4:0] s, input logic d, input logic [7:0] dw);
    u_if.req_valid_i = v;
    u_if.req_sel_i   = s;
    u_if.req_data_i  = d;
    u_if.req_dwell_i = dw;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    drive_req(1'b0, 5'd0, 1'b0, 8'd0);

    #1;
    chk("rst_ready", u_if.req_ready_o, 0);
    chk("rst_en", en_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_sel", sel_o, 0);
    chk("idle_data", data_o, 0);
    chk("idle_en", en_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_ready", u_if.req_ready_o, 1);
    chk("idle_level", level_o, 0);

    // Single request sel=7 data=1 dwell=3
    drive_req(1'b1, 5'd7, 1'b1, 8'd3);
    tick();
    drive_req(1'b0, 5'd0, 1'b0, 8'd0);
    chk("s1_level_n", level_o, 1);
    chk("s1_busy_n", busy_o, 1);
    chk("s1_en_n", en_o, 0);
    tick();
    chk("s1_sel_n1", sel_o, 7);
    chk("s1_data_n1", data_o, 1);
    chk("s1_en_n1", en_o, 0);
    chk("s1_level_n1", level_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s1_en_drive", en_o, 1);
      chk("s1_demux", w_demux, 32'h0000_0080);
    end
    tick();
    chk("s1_en_end", en_o, 0);
    chk("s1_busy_end", busy_o, 0);
    chk("s1_sel_hold", sel_o, 7);

    // Back-to-back: sel=0 data=0 dwell=0, then sel=31 data=1 dwell=2
    drive_req(1'b1, 5'd0, 1'b0, 8'd0);
    tick();
    drive_req(1'b1, 5'd31, 1'b1, 8'd2);
    tick();
    drive_req(1'b0, 5'd0, 1'b0, 8'd0);
    chk("b2b_setup_en", en_o, 0);
    chk("b2b_setup_sel", sel_o, 0);
    tick();
    chk("b2b_r0_en", en_o, 1);
    chk("b2b_r0_sel", sel_o, 0);
    chk("b2b_r0_demux", w_demux, 32'h0);
    tick();
    chk("b2b_gap_en", en_o, 0);
    chk("b2b_gap_sel", sel_o, 31);
    tick();
    chk("b2b_r1a_en", en_o, 1);
    chk("b2b_r1a_demux", w_demux, 32'h8000_0000);
    tick();
    chk("b2b_r1b_en", en_o, 1);
    chk("b2b_r1b_sel", sel_o, 31);
    tick();
    chk("b2b_end_en", en_o, 0);
    chk("b2b_end_busy", busy_o, 0);

    // Fill: long route plus four queued, sixth held until a slot frees
    drive_req(1'b1, 5'd3, 1'b1, 8'd255);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive_req(1'b1, 5'(9 + i), 1'b1, 8'd1);
      tick();
    end
    drive_req(1'b1, 5'd20, 1'b1, 8'd1);
    #1;
    chk("fill_level", level_o, 4);
    chk("fill_ready", u_if.req_ready_o, 0);
    chk("fill_en", en_o, 1);
    chk("fill_sel", sel_o, 3);
    n = 0;
    while (!u_if.req_ready_o && n < 400) begin
      tick();
      n++;
    end
    chk("fill_wait", n, 253);
    chk("fill_pop_sel", sel_o, 10);
    chk("fill_pop_en", en_o, 0);
    chk("fill_pop_level", level_o, 3);
    tick();
    drive_req(1'b0, 5'd0, 1'b0, 8'd0);
    chk("fill_accept_level", level_o, 4);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fill_flush_level", level_o, 0);

    // Flush mid-DRIVE with three queued
    drive_req(1'b1, 5'd9, 1'b1, 8'd20);
    tick();
    for (int i = 1; i <= 3; i++) begin
      drive_req(1'b1, 5'(i), 1'b1, 8'd5);
      tick();
    end
    chk("fl_pre_en", en_o, 1);
    chk("fl_pre_level", level_o, 3);
    flush = 1'b1;
    drive_req(1'b1, 5'd4, 1'b1, 8'd1);
    #1;
    chk("fl_ready", u_if.req_ready_o, 0);
    tick();
    flush = 1'b0;
    drive_req(1'b0, 5'd0, 1'b0, 8'd0);
    chk("fl_en", en_o, 0);
    chk("fl_sel", sel_o, 0);
    chk("fl_data", data_o, 0);
    chk("fl_level", level_o, 0);
    chk("fl_busy", busy_o, 0);
    tick();
    tick();
    tick();
    chk("fl_after_level", level_o, 0);
    chk("fl_after_en", en_o, 0);
    chk("fl_after_busy", busy_o, 0);

    // Asynchronous reset mid-DRIVE, between clock edges
    drive_req(1'b1, 5'd17, 1'b1, 8'd10);
    tick();
    drive_req(1'b1, 5'd2, 1'b1, 8'd4);
    tick();
    drive_req(1'b1, 5'd3, 1'b1, 8'd4);
    tick();
    drive_req(1'b0, 5'd0, 1'b0, 8'd0);
    chk("ar_pre_en", en_o, 1);
    chk("ar_pre_level", level_o, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_en", en_o, 0);
    chk("ar_sel", sel_o, 0);
    chk("ar_data", data_o, 0);
    chk("ar_level", level_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_ready", u_if.req_ready_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_rel_ready", u_if.req_ready_o, 1);
    chk("ar_rel_en", en_o, 0);
    chk("ar_rel_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
